// File: rtl/snake_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : snake_round_ctrl
// Brief   : Round sequencer for the snake game: top-level state, move strobe,
//           round countdown and game-logic reset pulse. Optional macro
//           SNAKE_SPEEDUP_EN derives speed_level from tail_count.
// Revision: 1.0 - initial release
// ============================================================================
module snake_round_ctrl #(
    parameter int TAIL_W        = 6,
    parameter int BASE_PERIOD   = 3_125_000,
    parameter int STEP_DEC      = 156_250,
    parameter int MIN_PERIOD    = 625_000,
    parameter int TICKS_PER_SEC = 25_000_000,
    parameter int ROUND_SECONDS = 90
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              btn_start,
    input  logic              btn_pause,
    input  logic              game_over,
    input  logic              game_won,
    input  logic [TAIL_W-1:0] tail_count,
    output logic              step_tick,
    output logic              game_rst,
    output logic              time_max_flag,
    output logic [2:0]        state,
    output logic [6:0]        seconds_left,
    output logic [3:0]        speed_level
);

    localparam int                 c_CNT_W    = $clog2(BASE_PERIOD + 1);
    localparam int                 c_PRE_W    = $clog2(TICKS_PER_SEC + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(BASE_PERIOD - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICKS_PER_SEC - 1);
    localparam logic [6:0]         c_SEC_INIT = 7'(ROUND_SECONDS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4,
        ST_WON   = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_start_q1, r_start_q2, r_start_e;
    logic               r_pause_q1, r_pause_q2, r_pause_e;
    logic [c_CNT_W-1:0] r_step_cnt;
    logic [c_PRE_W-1:0] r_presc;
    logic [6:0]         r_seconds;
    logic               r_time_max;
    logic               r_step_tick;
    logic               r_game_rst;
    logic [3:0]         r_speed;
    logic [3:0]         w_speed_next;
    logic [31:0]        w_period;

`ifdef SNAKE_SPEEDUP_EN
    logic [31:0] w_tail_q;
    logic [31:0] w_dec;
    assign w_tail_q     = 32'(tail_count) >> 2;
    assign w_speed_next = (w_tail_q > 32'd15) ? 4'd15 : 4'(w_tail_q);
    assign w_dec        = 32'(STEP_DEC) * 32'(r_speed);
    // Compare before subtracting so large speed levels cannot wrap below zero.
    assign w_period     = ((w_dec + 32'(MIN_PERIOD)) >= 32'(BASE_PERIOD)) ?
                          32'(MIN_PERIOD) : (32'(BASE_PERIOD) - w_dec);
`else
    logic w_unused_tail;
    assign w_unused_tail = ^tail_count;
    assign w_speed_next  = 4'd0;
    assign w_period      = 32'(BASE_PERIOD);
`endif

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (r_start_e) w_state_next = ST_CLEAR;
            ST_CLEAR: w_state_next = ST_PLAY;
            ST_PLAY: begin
                if (game_over)                    w_state_next = ST_OVER;
                else if (game_won || r_time_max)  w_state_next = ST_WON;
                else if (r_pause_e)               w_state_next = ST_PAUSE;
            end
            ST_PAUSE: if (r_pause_e) w_state_next = ST_PLAY;
            ST_OVER,
            ST_WON:   if (r_start_e) w_state_next = ST_CLEAR;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Registered edge strobes: one extra stage so every output stays registered.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_start_q1 <= 1'b0;
            r_start_q2 <= 1'b0;
            r_start_e  <= 1'b0;
            r_pause_q1 <= 1'b0;
            r_pause_q2 <= 1'b0;
            r_pause_e  <= 1'b0;
        end else begin
            r_start_q1 <= btn_start;
            r_start_q2 <= r_start_q1;
            r_start_e  <= r_start_q1 & ~r_start_q2;
            r_pause_q1 <= btn_pause;
            r_pause_q2 <= r_pause_q1;
            r_pause_e  <= r_pause_q1 & ~r_pause_q2;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_step_cnt  <= c_CNT_INIT;
            r_presc     <= '0;
            r_seconds   <= c_SEC_INIT;
            r_time_max  <= 1'b0;
            r_step_tick <= 1'b0;
            r_game_rst  <= 1'b0;
            r_speed     <= 4'd0;
        end else begin
            r_game_rst  <= (w_state_next == ST_CLEAR);
            r_step_tick <= 1'b0;
            r_speed     <= w_speed_next;
            if (w_state_next == ST_CLEAR) begin
                r_step_cnt <= c_CNT_INIT;
                r_presc    <= '0;
                r_seconds  <= c_SEC_INIT;
                r_time_max <= 1'b0;
            end else if (r_state == ST_PLAY) begin
                if (r_step_cnt == '0) begin
                    r_step_tick <= 1'b1;
                    r_step_cnt  <= c_CNT_W'(w_period - 32'd1);
                end else begin
                    r_step_cnt <= r_step_cnt - c_CNT_W'(1);
                end
                if (r_presc == c_PRE_LAST) begin
                    r_presc <= '0;
                    if (r_seconds != 7'd0) begin
                        r_seconds <= r_seconds - 7'd1;
                        if (r_seconds == 7'd1) r_time_max <= 1'b1;
                    end
                end else begin
                    r_presc <= r_presc + c_PRE_W'(1);
                end
            end
        end
    end

    assign state         = r_state;
    assign step_tick     = r_step_tick;
    assign game_rst      = r_game_rst;
    assign time_max_flag = r_time_max;
    assign seconds_left  = r_seconds;
    assign speed_level   = r_speed;

endmodule
`default_nettype wire

// File: doc/snake_round_ctrl.md
# snake_round_ctrl

Round sequencer for the snake cartridge. It owns the game's top-level state (idle, play, pause, over, won) and issues the single-cycle move strobe that advances the snake. It also runs the round countdown that drives `time_max_flag`, and pulses the reset into the game logic at round start. It sits between the debounced button inputs and `game_logic`, entirely in the `vga_clk` domain.

## Interface
Parameters:
- `TAIL_W`, 6: width of `tail_count`.
- `BASE_PERIOD`, 3_125_000: `vga_clk` cycles per move at speed level 0.
- `STEP_DEC`, 156_250: cycles removed from the period per speed level.
- `MIN_PERIOD`, 625_000: floor on the move period.
- `TICKS_PER_SEC`, 25_000_000: `vga_clk` cycles per countdown second.
- `ROUND_SECONDS`, 90: round length, 1..127.

Ports:
- `vga_clk`  in  1  system/pixel clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `btn_start`  in  1  debounced, synchronous level.
- `btn_pause`  in  1  debounced, synchronous level.
- `game_over`  in  1  from game logic.
- `game_won`  in  1  from game logic.
- `tail_count`  in  TAIL_W  current tail length.
- `step_tick`  out  1  one-cycle move strobe.
- `game_rst`  out  1  one-cycle reset pulse to game logic.
- `time_max_flag`  out  1  round time expired, level.
- `state`  out  3  IDLE=0, CLEAR=1, PLAY=2, PAUSE=3, OVER=4, WON=5.
- `seconds_left`  out  7  remaining round seconds.
- `speed_level`  out  4  current speed level.

## Operation
- Button edges: a registered copy of each button gives a rising-edge strobe `start_e` / `pause_e`. A level held high produces exactly one edge.
- FSM transitions:
  - IDLE: `start_e` → CLEAR.
  - CLEAR: lasts exactly one cycle with `game_rst`=1. It reloads the step counter with `BASE_PERIOD`-1, `seconds_left`=`ROUND_SECONDS` and the second prescaler=0, and clears `time_max_flag`. Then → PLAY.
  - PLAY, first matching rule wins:
    1. `game_over` → OVER.
    2. `game_won` or `time_max_flag` → WON.
    3. `pause_e` → PAUSE.
  - PAUSE: `pause_e` → PLAY. `game_over`/`game_won` are ignored while paused.
  - OVER and WON: `start_e` → CLEAR.
  - Encodings 6 and 7 recover to IDLE.
- Step counter:
  - Decrements only in PLAY.
  - When it reaches 0: `step_tick`=1 for that cycle and the counter reloads with `period`-1.
  - `period` = max(`BASE_PERIOD` − `STEP_DEC`·`speed_level`, `MIN_PERIOD`), computed at reload only. A speed change therefore takes effect from the next interval.
  - Counter holds in PAUSE, OVER and WON; no ticks are issued outside PLAY.
- Countdown:
  - In PLAY the prescaler counts 0..`TICKS_PER_SEC`-1. On wrap, `seconds_left` decrements.
  - When `seconds_left` goes 1→0, `time_max_flag` sets and stays high until CLEAR.
  - `seconds_left` saturates at 0. Prescaler and seconds hold outside PLAY.
- `speed_level`: see Configuration; updated every cycle.
- Reset mid-round: all state returns to reset values immediately; any in-flight tick or second is discarded.

## Timing
- Reset values:
  - `state`=IDLE
  - `step_tick`=0
  - `game_rst`=0
  - `time_max_flag`=0
  - `seconds_left`=`ROUND_SECONDS`
  - `speed_level`=0
  - step counter=`BASE_PERIOD`-1
- All outputs are registered.
- Latencies from a button rising edge (button sampled high at edge N):
  - `start_e` at N+1.
  - `state`=CLEAR and `game_rst`=1 at N+2.
  - PLAY at N+3.
- First `step_tick` in a round arrives exactly `BASE_PERIOD` cycles after PLAY entry.
- `step_tick` and a state change in the same cycle: the tick is still issued if the counter hit 0 while `state` was PLAY.
- `game_over` and `game_won` together in PLAY → OVER.

## Configuration
- `SNAKE_SPEEDUP_EN` defined: `speed_level` = min(`tail_count`>>2, 15). The move period shrinks as the snake grows.
- Not defined: `speed_level` is tied to 0 and the period is constant at `BASE_PERIOD`. The multiplier/clamp logic is removed.

## Test plan
Common bench parameters: `BASE_PERIOD`=10, `STEP_DEC`=2, `MIN_PERIOD`=4, `TICKS_PER_SEC`=20, `ROUND_SECONDS`=3.

- Start from reset:
  - Stimulus: `btn_start` high for 5 cycles.
  - Response: one `game_rst` pulse, then PLAY; `step_tick` every 10 cycles.
  - Check: `seconds_left` reads 2 after 20 PLAY cycles.
- Pause and resume:
  - Stimulus: `pause_e` at PLAY+7, 30 cycles in PAUSE, then `pause_e` again.
  - Response: no ticks and `seconds_left` frozen during PAUSE; next tick exactly 3 PLAY cycles after resume.
- Timeout:
  - Stimulus: run 60 PLAY cycles.
  - Response: `seconds_left`=0 and `time_max_flag`=1 at cycle 60; WON one cycle later.
  - Check: `start_e` in WON clears the flag via CLEAR.
- Priority:
  - Stimulus: `game_over`=`game_won`=1 in the same PLAY cycle.
  - Response: OVER.
  - Check: `game_over` asserted while in PAUSE causes no transition.
- Speed-up (`SNAKE_SPEEDUP_EN`):
  - Stimulus: `tail_count`=8.
  - Response: `speed_level`=2; period 6 from the next reload.
  - Stimulus: `tail_count`=40.
  - Response: `speed_level`=10; period clamps to 4.
  - Without the macro: period stays 10.
- Async reset in PLAY:
  - Stimulus: assert `reset` between edges.
  - Response: IDLE, `seconds_left`=3, all strobes 0 before the next edge.
